reg_writeback_queue: RTL



---
 rtl/reg_writeback_queue.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/reg_writeback_queue.sv
// Writeback queue feeding the register file: merges ALU and load results in order and exposes a pending mask.
// Optional combinational forwarding ports are enabled with the WB_FORWARD_EN macro.
module reg_writeback_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 4,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alu_valid,
    input  logic [AW-1:0]            alu_dir,
    input  logic [DW-1:0]            alu_data,
    output logic                     alu_ready,
    input  logic                     ld_valid,
    input  logic [AW-1:0]            ld_dir,
    input  logic [DW-1:0]            ld_data,
    output logic                     ld_ready,
    output logic [AW-1:0]            wb_dir,
    output logic [DW-1:0]            wb_data,
    output logic                     wb_we_n,
    output logic [(1<<AW)-1:0]       pending,
`ifdef WB_FORWARD_EN
    input  logic [AW-1:0]            fwd_dir_a,
    input  logic [AW-1:0]            fwd_dir_b,
    output logic                     fwd_hit_a,
    output logic                     fwd_hit_b,
    output logic [DW-1:0]            fwd_data_a,
    output logic [DW-1:0]            fwd_data_b,
`endif
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;
    localparam int NREG = 1 << AW;
    localparam logic [CW-1:0] FULL     = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_LEFT = CW'(DEPTH - 1);
    localparam logic [CW-1:0] TWO_LEFT = CW'(DEPTH - 2);

    logic [AW-1:0] dir_q  [DEPTH];
    logic [AW-1:0] dir_d  [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [DW-1:0] data_d [DEPTH];
    logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] wb_dir_q, wb_dir_d;
    logic [DW-1:0] wb_data_q, wb_data_d;
    logic          wb_we_n_q, wb_we_n_d;
    logic          alu_acc, ld_acc, pop;
    logic [PW-1:0] ld_slot;

    // Readiness looks only at the registered occupancy, never at this cycle's pop.
    assign alu_ready = (count_q < FULL);
    assign ld_ready  = (count_q <= TWO_LEFT) || ((count_q == ONE_LEFT) && !alu_valid);
    assign alu_acc   = alu_valid && alu_ready;
    assign ld_acc    = ld_valid && ld_ready;
    assign pop       = (count_q != '0);
    assign ld_slot   = wp_q + PW'(alu_acc);

    always_comb begin
        dir_d     = dir_q;
        data_d    = data_q;
        wp_d      = wp_q + PW'(alu_acc) + PW'(ld_acc);
        rp_d      = rp_q;
        wb_dir_d  = wb_dir_q;
        wb_data_d = wb_data_q;
        wb_we_n_d = 1'b1;
        count_d   = count_q + CW'(alu_acc) + CW'(ld_acc) - CW'(pop);
        if (alu_acc) begin
            dir_d[wp_q]  = alu_dir;
            data_d[wp_q] = alu_data;
        end
        if (ld_acc) begin
            dir_d[ld_slot]  = ld_dir;
            data_d[ld_slot] = ld_data;
        end
        if (pop) begin
            wb_dir_d  = dir_q[rp_q];
            wb_data_d = data_q[rp_q];
            wb_we_n_d = 1'b0;
            rp_d      = rp_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                dir_q[i]  <= '0;
                data_q[i] <= '0;
            end
            wp_q      <= '0;
            rp_q      <= '0;
            count_q   <= '0;
            wb_dir_q  <= '0;
            wb_data_q <= '0;
            wb_we_n_q <= 1'b1;
        end else begin
            dir_q     <= dir_d;
            data_q    <= data_d;
            wp_q      <= wp_d;
            rp_q      <= rp_d;
            count_q   <= count_d;
            wb_dir_q  <= wb_dir_d;
            wb_data_q <= wb_data_d;
            wb_we_n_q <= wb_we_n_d;
        end
    end

    // Hazard mask covers every occupied slot plus the write currently strobing.
    always_comb begin
        logic [PW-1:0] slot;
        slot    = '0;
        pending = '0;
        if (!wb_we_n_q) pending[wb_dir_q] = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            slot = rp_q + PW'(i);
            if (CW'(i) < count_q) pending[dir_q[slot]] = 1'b1;
        end
    end

`ifdef WB_FORWARD_EN
    // Scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        logic [PW-1:0] slot;
        slot       = '0;
        fwd_hit_a  = 1'b0;
        fwd_hit_b  = 1'b0;
        fwd_data_a = '0;
        fwd_data_b = '0;
        if (!wb_we_n_q && (wb_dir_q == fwd_dir_a)) begin
            fwd_hit_a  = 1'b1;
            fwd_data_a = wb_data_q;
        end
        if (!wb_we_n_q && (wb_dir_q == fwd_dir_b)) begin
            fwd_hit_b  = 1'b1;
            fwd_data_b = wb_data_q;
        end
        for (int i = 0; i < DEPTH; i++) begin
            slot = rp_q + PW'(i);
            if ((CW'(i) < count_q) && (dir_q[slot] == fwd_dir_a)) begin
                fwd_hit_a  = 1'b1;
                fwd_data_a = data_q[slot];
            end
            if ((CW'(i) < count_q) && (dir_q[slot] == fwd_dir_b)) begin
                fwd_hit_b  = 1'b1;
                fwd_data_b = data_q[slot];
            end
        end
    end
`endif

    assign wb_dir  = wb_dir_q;
    assign wb_data = wb_data_q;
    assign wb_we_n = wb_we_n_q;
    assign count   = count_q;

    localparam int UNUSED_NREG = NREG;
endmodule
